// File: rtl/timer_pkg.sv
// timer_pkg: shared state encoding and channel mode constants for the multi-channel timer.
package timer_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_e;
  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;
endpackage

// File: rtl/timer_multi_ch_if.sv
// timer_multi_ch_if: control/status bundle between a timer client and the multi-channel timer.
interface timer_multi_ch_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
);
  logic                    cnt_pulse;
  logic [NUM_CH-1:0]       ch_en;
  logic [NUM_CH-1:0]       ch_mode;
  logic [NUM_CH*CNT_W-1:0] ch_term;
  logic [NUM_CH-1:0]       ch_clr;
  logic [NUM_CH-1:0]       timeout;
  logic [NUM_CH-1:0]       expired;
  logic [NUM_CH-1:0]       running;
  modport master (output cnt_pulse, ch_en, ch_mode, ch_term, ch_clr, input timeout, expired, running);
  modport slave  (input cnt_pulse, ch_en, ch_mode, ch_term, ch_clr, output timeout, expired, running);
endinterface

// File: rtl/timer_ch.sv
// timer_ch: one tick-driven timer channel with one-shot/periodic modes and a sticky expiry flag.
module timer_ch
  import timer_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             cnt_pulse_i,
  input  logic             ch_en_i,
  input  logic             ch_mode_i,
  input  logic [CNT_W-1:0] ch_term_i,
  input  logic             ch_clr_i,
  output logic             timeout_o,
  output logic             expired_o,
  output logic             running_o
);
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q, term_q;
  logic             mode_q, timeout_q, expired_q, running_q, hit_d;
  // Expiry is decided from the current count so the wrap costs no extra tick.
  assign hit_d = ch_en_i && state_q == ST_RUN && cnt_pulse_i && cnt_q == term_q - 1'b1;
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      term_q    <= '0;
      mode_q    <= MODE_ONESHOT;
      timeout_q <= 1'b0;
      expired_q <= 1'b0;
      running_q <= 1'b0;
    end else begin
      timeout_q <= hit_d;
      expired_q <= hit_d | (expired_q & ~ch_clr_i);
      if (!ch_en_i) begin
        state_q   <= ST_IDLE;
        cnt_q     <= '0;
        running_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            term_q    <= (ch_term_i == '0) ? CNT_W'(1) : ch_term_i;
            mode_q    <= ch_mode_i;
            cnt_q     <= '0;
            state_q   <= ST_RUN;
            running_q <= 1'b1;
          end
          ST_RUN: begin
            if (hit_d) begin
              cnt_q     <= '0;
              state_q   <= (mode_q == MODE_PERIODIC) ? ST_RUN : ST_DONE;
              running_q <= mode_q != MODE_ONESHOT;
            end else if (cnt_pulse_i) begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          ST_DONE: cnt_q <= '0;
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end
  assign timeout_o = timeout_q;
  assign expired_o = expired_q;
  assign running_o = running_q;
endmodule

// File: rtl/timer_multi_ch.sv
// timer_multi_ch: NUM_CH independent timer channels sharing one prescaler tick strobe.
module timer_multi_ch #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  timer_multi_ch_if.slave   bus
);
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    timer_ch #(.CNT_W(CNT_W)) u_ch (
      .sys_clk     (sys_clk),
      .sys_rst_n   (sys_rst_n),
      .cnt_pulse_i (bus.cnt_pulse),
      .ch_en_i     (bus.ch_en[i]),
      .ch_mode_i   (bus.ch_mode[i]),
      .ch_term_i   (bus.ch_term[i*CNT_W +: CNT_W]),
      .ch_clr_i    (bus.ch_clr[i]),
      .timeout_o   (bus.timeout[i]),
      .expired_o   (bus.expired[i]),
      .running_o   (bus.running[i])
    );
  end
endmodule

// File: tb/tb_timer_multi_ch.sv
// tb_timer_multi_ch: directed self-checking bench for the multi-channel timer.
module tb_timer_multi_ch;
  import timer_pkg::*;
  localparam int N = 4;
  localparam int W = 16;
  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  timer_multi_ch_if #(.NUM_CH(N), .CNT_W(W)) bus();
  timer_multi_ch #(.NUM_CH(N), .CNT_W(W)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );
  always #5 sys_clk = ~sys_clk;
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask
  task automatic idle_all();
    bus.cnt_pulse = 1'b0;
    bus.ch_en = '0;
    bus.ch_clr = '1;
    tick();
    bus.ch_clr = '0;
  endtask
  task automatic test_reset();
    bus.cnt_pulse = 1'b0;
    bus.ch_en = '0;
    bus.ch_mode = '0;
    bus.ch_term = '0;
    bus.ch_clr = '0;
    sys_rst_n = 1'b0;
    tick();
    tick();
    tests++;
    if ({bus.timeout, bus.expired, bus.running} !== 12'h000) begin
      fails++;
      $display("FAIL reset_init: got %03h expected 000", {bus.timeout, bus.expired, bus.running});
    end
    sys_rst_n = 1'b1;
    tick();
    bus.ch_term[W-1:0] = 16'd3;
    bus.ch_mode[0] = MODE_PERIODIC;
    bus.ch_en = 4'b0001;
    tick();
    bus.cnt_pulse = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    tests++;
    if ({bus.expired[0], bus.running[0]} !== 2'b11) begin
      fails++;
      $display("FAIL reset_prerun: got %b expected 11", {bus.expired[0], bus.running[0]});
    end
    sys_rst_n = 1'b0;
    #1;
    tests++;
    if ({bus.timeout, bus.expired, bus.running} !== 12'h000) begin
      fails++;
      $display("FAIL reset_async: got %03h expected 000", {bus.timeout, bus.expired, bus.running});
    end
    bus.ch_en = '0;
    bus.cnt_pulse = 1'b0;
    sys_rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests++;
      if ({bus.timeout, bus.running} !== 8'h00) begin
        fails++;
        $display("FAIL reset_release: got %02h expected 00", {bus.timeout, bus.running});
      end
    end
  endtask
  task automatic test_oneshot();
    bus.ch_mode = '0;
    bus.ch_term = '0;
    bus.ch_term[W-1:0] = 16'd5;
    bus.ch_en = 4'b0001;
    tick();
    tests++;
    if (bus.running !== 4'b0001) begin
      fails++;
      $display("FAIL oneshot_start: running got %b expected 0001", bus.running);
    end
    for (int p = 1; p <= 5; p++) begin
      bus.cnt_pulse = 1'b1;
      tick();
      bus.cnt_pulse = 1'b0;
      tests++;
      if (bus.timeout !== ((p == 5) ? 4'b0001 : 4'b0000)) begin
        fails++;
        $display("FAIL oneshot_pulse%0d: timeout got %b expected %b", p, bus.timeout, (p == 5) ? 4'b0001 : 4'b0000);
      end
      if (p == 5) begin
        tests++;
        if ({bus.expired, bus.running} !== 8'h10) begin
          fails++;
          $display("FAIL oneshot_flags: got %02h expected 10", {bus.expired, bus.running});
        end
      end else begin
        for (int k = 0; k < 3; k++) begin
          tick();
          tests++;
          if (bus.timeout !== 4'b0000) begin
            fails++;
            $display("FAIL oneshot_gap: timeout got %b expected 0000", bus.timeout);
          end
        end
      end
    end
    tick();
    tests++;
    if (bus.timeout !== 4'b0000) begin
      fails++;
      $display("FAIL oneshot_width: timeout got %b expected 0000", bus.timeout);
    end
    bus.cnt_pulse = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      tests++;
      if ({bus.timeout, bus.running} !== 8'h00) begin
        fails++;
        $display("FAIL oneshot_done: got %02h expected 00", {bus.timeout, bus.running});
      end
    end
    idle_all();
    tests++;
    if (bus.expired !== 4'b0000) begin
      fails++;
      $display("FAIL oneshot_clr: expired got %b expected 0000", bus.expired);
    end
  endtask
  task automatic test_periodic();
    int n_to;
    n_to = 0;
    bus.ch_mode = 4'b0001;
    bus.ch_term = '0;
    bus.ch_term[W-1:0] = 16'd3;
    bus.ch_en = 4'b0001;
    tick();
    bus.cnt_pulse = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (bus.timeout[0]) n_to++;
      tests++;
      if ({bus.timeout[0], bus.running[0]} !== {c % 3 == 0, 1'b1}) begin
        fails++;
        $display("FAIL periodic_c%0d: got %b expected %b", c, {bus.timeout[0], bus.running[0]}, {c % 3 == 0, 1'b1});
      end
    end
    tests++;
    if (n_to != 4) begin
      fails++;
      $display("FAIL periodic_count: got %0d expected 4", n_to);
    end
    idle_all();
  endtask
  task automatic test_disable();
    bus.ch_mode = '0;
    bus.ch_term = '0;
    bus.ch_term[W-1:0] = 16'd10;
    bus.ch_en = 4'b0001;
    tick();
    bus.cnt_pulse = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    bus.cnt_pulse = 1'b0;
    bus.ch_en = '0;
    tick();
    tests++;
    if ({bus.timeout, bus.expired, bus.running} !== 12'h000) begin
      fails++;
      $display("FAIL disable_idle: got %03h expected 000", {bus.timeout, bus.expired, bus.running});
    end
    bus.ch_en = 4'b0001;
    tick();
    bus.cnt_pulse = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      tests++;
      if (bus.timeout[0] !== (i == 10)) begin
        fails++;
        $display("FAIL disable_rerun%0d: timeout got %b expected %b", i, bus.timeout[0], i == 10);
      end
    end
    idle_all();
  endtask
  task automatic test_clr_race();
    bus.ch_mode = 4'b0001;
    bus.ch_term = '0;
    bus.ch_term[W-1:0] = 16'd2;
    bus.ch_en = 4'b0001;
    tick();
    bus.cnt_pulse = 1'b1;
    tick();
    bus.ch_clr = 4'b0001;
    tick();
    tests++;
    if ({bus.timeout[0], bus.expired[0]} !== 2'b11) begin
      fails++;
      $display("FAIL clr_race_set: got %b expected 11", {bus.timeout[0], bus.expired[0]});
    end
    bus.cnt_pulse = 1'b0;
    tick();
    tests++;
    if ({bus.expired[0], bus.running[0]} !== 2'b01) begin
      fails++;
      $display("FAIL clr_race_clear: got %b expected 01", {bus.expired[0], bus.running[0]});
    end
    bus.ch_clr = '0;
    idle_all();
  endtask
  task automatic test_multi();
    logic [N-1:0] exp_to;
    bus.ch_term = {16'hFFFF, 16'h0000, 16'h0000, 16'h0002};
    bus.ch_mode = 4'b0001;
    bus.ch_en = 4'b1011;
    tick();
    tests++;
    if (bus.running !== 4'b1011) begin
      fails++;
      $display("FAIL multi_start: running got %b expected 1011", bus.running);
    end
    bus.cnt_pulse = 1'b1;
    for (int p = 1; p <= 65535; p++) begin
      tick();
      exp_to = {p == 65535, 1'b0, p == 1, p % 2 == 0};
      tests++;
      if (bus.timeout !== exp_to) begin
        fails++;
        $display("FAIL multi_p%0d: timeout got %b expected %b", p, bus.timeout, exp_to);
      end
    end
    bus.cnt_pulse = 1'b0;
    tests++;
    if ({bus.expired, bus.running} !== 8'hB1) begin
      fails++;
      $display("FAIL multi_end: got %02h expected b1", {bus.expired, bus.running});
    end
    idle_all();
  endtask
  initial begin
    test_reset();
    test_oneshot();
    test_periodic();
    test_disable();
    test_clr_race();
    test_multi();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
